// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch-stage program counter.
//   - Default values for PC width, reset/trap vectors, increment and RAS depth.
//   - pc_sel_t: next-PC mux select.
//   - encode_sel(): fixed-priority encoder from redirect/stall requests to
//     pc_sel_t (trap > return > branch > stall > sequential).
// -----------------------------------------------------------------------------
package pc_pkg;

    localparam int unsigned PC_W_DEF      = 8;
    localparam int unsigned RESET_VEC_DEF = 'h00;
    localparam int unsigned TRAP_VEC_DEF  = 'hF0;
    localparam int unsigned INC_DEF       = 1;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BR,
        SEL_RET,
        SEL_TRAP
    } pc_sel_t;

    // Redirects outrank stall: EX-resolved control flow must never be held off
    // by a fetch-side hazard.
    function automatic pc_sel_t encode_sel(
        input logic trap,
        input logic ret_e,
        input logic branch_take,
        input logic stall_f
    );
        if (trap)             return SEL_TRAP;
        else if (ret_e)       return SEL_RET;
        else if (branch_take) return SEL_BR;
        else if (stall_f)     return SEL_HOLD;
        else                  return SEL_SEQ;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Circular return-address stack. top points at the most recent entry; a push
// writes at top+1, so when the stack is full the write lands on the oldest
// entry and silently replaces it.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   push, push_data   push request and return address to store
//   pop               pop request (wins over push in the same cycle)
//   top_data          entry at the top pointer (valid only when !empty)
//   empty, full       count == 0 / count == DEPTH
//   err               registered one-cycle pulse: underflow, overflow or
//                     simultaneous push/pop
// -----------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned W     = PC_W_DEF,
    parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] top_data,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;
    logic             err_now;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign top_data = mem[top];

    // A pop always takes precedence; the push in a conflicting cycle is dropped.
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~pop;
    assign wr_ptr  = top + PTR_W'(1);

    assign err_now = (pop & empty) | (push & pop) | (push & ~pop & full);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (do_pop) begin
                top   <= top - PTR_W'(1);
                count <= count - CNT_W'(1);
            end else if (do_push) begin
                top <= wr_ptr;
                if (!full) count <= count + CNT_W'(1);
            end
            err <= err_now;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; an entry is
    // only ever read after it has been written, because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Fetch-stage program counter with prioritised redirects, stall hold and a
// return-address stack.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   stall_f             hold pc (hazard unit)
//   branch_take         taken branch/jump from EX, target on branch_target
//   call_e              call from EX: push call_ret_addr onto the RAS
//   ret_e               return from EX: pop RAS, redirect to popped value
//   trap                exception: redirect to TRAP_VEC
//   pc                  registered fetch address
//   pc_plus             pc + INC (combinational, wraps mod 2^PC_W)
//   flush_d             a redirect is taken this cycle; IF/ID must flush
//   ras_empty/ras_full  RAS occupancy flags
//   ras_err             one-cycle pulse on RAS underflow/overflow/conflict
// -----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned          PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0]      RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter logic [PC_W-1:0]      TRAP_VEC  = PC_W'(TRAP_VEC_DEF),
    parameter int unsigned          INC       = INC_DEF,
    parameter int unsigned          RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            branch_take,
    input  logic [PC_W-1:0] branch_target,
    input  logic            call_e,
    input  logic [PC_W-1:0] call_ret_addr,
    input  logic            ret_e,
    input  logic            trap,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic            flush_d,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    pc_sel_t         sel;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] ras_top;

    // RAS operations follow EX directly: neither stall_f nor trap gates them.
    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (call_e),
        .push_data (call_ret_addr),
        .pop       (ret_e),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .err       (ras_err)
    );

    assign pc_plus = pc + PC_W'(INC);
    assign flush_d = trap | ret_e | branch_take;

    // NOTE: next_pc gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        sel     = encode_sel(trap, ret_e, branch_take, stall_f);
        next_pc = pc_plus;
        case (sel)
            SEL_TRAP: next_pc = TRAP_VEC;
            // A return with nothing on the stack is treated like a trap.
            SEL_RET:  next_pc = ras_empty ? TRAP_VEC : ras_top;
            SEL_BR:   next_pc = branch_target;
            SEL_HOLD: next_pc = pc;
            SEL_SEQ:  next_pc = pc_plus;
            default:  next_pc = pc_plus;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= RESET_VEC;
        else       pc <= next_pc;
    end

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit (PC_W=8, INC=1, RAS_DEPTH=4). A reference
// model keeps the PC as a plain byte and the RAS as a bounded queue.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall_f, branch_take, call_e, ret_e, trap;
    logic [7:0] branch_target, call_ret_addr;
    logic [7:0] pc, pc_plus;
    logic       flush_d, ras_empty, ras_full, ras_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] m_pc;
    logic [7:0] m_q[$];
    logic       m_err;

    // combinational observations taken mid-cycle by cycle()
    logic       obs_flush, exp_flush;
    logic [7:0] obs_plus, exp_plus;

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall_f       (stall_f),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .call_e        (call_e),
        .call_ret_addr (call_ret_addr),
        .ret_e         (ret_e),
        .trap          (trap),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .flush_d       (flush_d),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        stall_f = 0; branch_take = 0; branch_target = '0;
        call_e = 0; call_ret_addr = '0; ret_e = 0; trap = 0;
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_q.delete();
        m_err = 1'b0;
    endtask

    // Apply one cycle of inputs, capture combinational outputs, clock once,
    // advance the model, then return inputs to idle.
    task automatic cycle(input logic st, input logic br, input logic [7:0] tgt,
                         input logic call, input logic [7:0] ca,
                         input logic ret, input logic tr);
        logic [7:0] retv;
        stall_f = st; branch_take = br; branch_target = tgt;
        call_e = call; call_ret_addr = ca; ret_e = ret; trap = tr;
        #1;
        obs_flush = flush_d;
        obs_plus  = pc_plus;
        exp_flush = tr | ret | br;
        exp_plus  = m_pc + 8'd1;
        @(posedge clk);
        retv  = 8'hF0;
        m_err = 1'b0;
        if (ret) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else retv = m_q.pop_back();
            if (call) m_err = 1'b1;
        end else if (call) begin
            if (m_q.size() == 4) begin
                void'(m_q.pop_front());
                m_err = 1'b1;
            end
            m_q.push_back(ca);
        end
        if (tr)       m_pc = 8'hF0;
        else if (ret) m_pc = retv;
        else if (br)  m_pc = tgt;
        else if (!st) m_pc = m_pc + 8'd1;
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        // fill the RAS and overflow it while branching to 0x37
        cycle(0, 1, 8'h20, 1, 8'h11, 0, 0);
        cycle(0, 0, 8'h00, 1, 8'h22, 0, 0);
        cycle(0, 0, 8'h00, 1, 8'h33, 0, 0);
        cycle(0, 0, 8'h00, 1, 8'h44, 0, 0);
        cycle(0, 1, 8'h37, 1, 8'h55, 0, 0);
        total++;
        if (pc !== 8'h37 || ras_err !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre: pc=%h err=%b want pc=37 err=1", pc, ras_err);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (pc !== 8'h00 || ras_empty !== 1'b1 || ras_err !== 1'b0 || ras_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: pc=%h empty=%b full=%b err=%b want 00 1 0 0",
                     pc, ras_empty, ras_full, ras_err);
        end
        @(negedge clk) reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 8'h00, 0, 8'h00, 0, 0);
            total++;
            if (pc !== 8'(i)) begin
                bad++;
                $display("FAIL reset_free_run: pc=%h want %h", pc, 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        cycle(0, 1, 8'hFF, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 8'h00, 0, 0);
        total++;
        if (obs_plus !== 8'h00 || pc !== 8'h00 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL wrap: plus_at_ff=%h pc=%h err=%b want 00 00 0", obs_plus, pc, ras_err);
        end
        #1;
        total++;
        if (pc_plus !== 8'h01) begin
            bad++;
            $display("FAIL wrap_plus: pc_plus=%h want 01", pc_plus);
        end
    endtask

    task automatic test_stall();
        cycle(0, 1, 8'h10, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
            total++;
            if (pc !== 8'h10 || obs_flush !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: pc=%h flush=%b want 10 0", pc, obs_flush);
            end
        end
        cycle(1, 1, 8'h40, 0, 8'h00, 0, 0);
        total++;
        if (pc !== 8'h40 || obs_flush !== 1'b1) begin
            bad++;
            $display("FAIL stall_branch: pc=%h flush=%b want 40 1", pc, obs_flush);
        end
    endtask

    task automatic test_trap_priority();
        cycle(0, 1, 8'h80, 1, 8'h5A, 0, 0);
        cycle(0, 0, 8'h00, 1, 8'h6B, 0, 0);
        cycle(0, 1, 8'h90, 0, 8'h00, 1, 1);
        total++;
        if (pc !== 8'hF0 || obs_flush !== 1'b1 || ras_empty !== 1'b0) begin
            bad++;
            $display("FAIL trap_priority: pc=%h flush=%b empty=%b want F0 1 0",
                     pc, obs_flush, ras_empty);
        end
        // exactly one entry popped: next return must yield 0x5A
        cycle(0, 0, 8'h00, 0, 8'h00, 1, 0);
        total++;
        if (pc !== 8'h5A || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL trap_pop_once: pc=%h empty=%b want 5A 1", pc, ras_empty);
        end
    endtask

    task automatic test_ras_overflow_underflow();
        logic [7:0] want;
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 1, 8'h30, 1, 8'(i * 'h11), 0, 0);
            total++;
            if (ras_err !== (i == 5) || ras_full !== (i >= 4)) begin
                bad++;
                $display("FAIL ras_push%0d: err=%b full=%b want %b %b",
                         i, ras_err, ras_full, (i == 5), (i >= 4));
            end
        end
        for (int i = 5; i >= 2; i--) begin
            want = 8'(i * 'h11);
            cycle(0, 0, 8'h00, 0, 8'h00, 1, 0);
            total++;
            if (pc !== want || ras_err !== 1'b0) begin
                bad++;
                $display("FAIL ras_pop: pc=%h err=%b want %h 0", pc, ras_err, want);
            end
        end
        cycle(0, 0, 8'h00, 0, 8'h00, 1, 0);
        total++;
        if (pc !== 8'hF0 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL ras_underflow: pc=%h err=%b empty=%b want F0 1 1", pc, ras_err, ras_empty);
        end
        cycle(0, 0, 8'h00, 0, 8'h00, 0, 0);
        total++;
        if (ras_err !== 1'b0) begin
            bad++;
            $display("FAIL ras_err_clear: err=%b want 0", ras_err);
        end
    endtask

    task automatic test_call_ret_conflict();
        cycle(0, 1, 8'h50, 1, 8'h66, 0, 0);
        cycle(0, 1, 8'h70, 1, 8'h21, 1, 0);
        total++;
        if (pc !== 8'h66 || ras_err !== 1'b1 || ras_empty !== 1'b1) begin
            bad++;
            $display("FAIL conflict: pc=%h err=%b empty=%b want 66 1 1", pc, ras_err, ras_empty);
        end
        cycle(0, 0, 8'h00, 0, 8'h00, 0, 0);
        total++;
        if (ras_err !== 1'b0 || pc !== 8'h67) begin
            bad++;
            $display("FAIL conflict_after: pc=%h err=%b want 67 0", pc, ras_err);
        end
    endtask

    task automatic test_random();
        logic st, br, call, ret, tr;
        for (int i = 0; i < 400; i++) begin
            st   = ($urandom_range(0, 3) == 0);
            br   = ($urandom_range(0, 3) == 0);
            call = ($urandom_range(0, 3) == 0);
            ret  = ($urandom_range(0, 4) == 0);
            tr   = ($urandom_range(0, 15) == 0);
            cycle(st, br, 8'($urandom), call, 8'($urandom), ret, tr);
            total++;
            if (pc !== m_pc || ras_err !== m_err || obs_flush !== exp_flush ||
                obs_plus !== exp_plus || ras_empty !== (m_q.size() == 0) ||
                ras_full !== (m_q.size() == 4)) begin
                bad++;
                $display("FAIL random[%0d]: pc=%h/%h err=%b/%b flush=%b/%b plus=%h/%h empty=%b full=%b size=%0d",
                         i, pc, m_pc, ras_err, m_err, obs_flush, exp_flush,
                         obs_plus, exp_plus, ras_empty, ras_full, m_q.size());
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #7;
        total++;
        if (pc !== 8'h00 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: pc=%h empty=%b full=%b err=%b want 00 1 0 0",
                     pc, ras_empty, ras_full, ras_err);
        end
        #5 reset = 1'b0;
        test_reset();
        test_wrap();
        test_stall();
        test_trap_priority();
        test_ras_overflow_underflow();
        test_call_ret_conflict();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
